// File: rtl/rv32m_pkg.sv
// Shared RV32M multiply definitions: funct3 encodings, issue FSM states and
// the decoded operation flags.
package rv32m_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BUSY,
        RESP,
        DRAIN
    } state_t;

    typedef struct packed {
        logic legal;
        logic signed_a;
        logic signed_b;
        logic upper;
    } mul_flags_t;

endpackage

// File: rtl/mul_decode.sv
// Combinational funct3 decode for the multiply group. DIV/REM encodings
// (funct3[2]=1) are reported as illegal with all operand flags cleared.
module mul_decode
    import rv32m_pkg::*;
(
    input  logic [2:0]  funct3,
    output mul_flags_t  flags
);

    // Map funct3 onto signedness / high-word selection
    always_comb begin
        flags = '0;
        unique case (funct3)
            F3_MUL:    flags = '{legal: 1'b1, signed_a: 1'b1, signed_b: 1'b1, upper: 1'b0};
            F3_MULH:   flags = '{legal: 1'b1, signed_a: 1'b1, signed_b: 1'b1, upper: 1'b1};
            F3_MULHSU: flags = '{legal: 1'b1, signed_a: 1'b1, signed_b: 1'b0, upper: 1'b1};
            F3_MULHU:  flags = '{legal: 1'b1, signed_a: 1'b0, signed_b: 1'b0, upper: 1'b1};
            default:   flags = '0;
        endcase
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/response controller in front of the RV32M multiplier. Accepts one
// request at a time, starts the multiplier with a single-cycle pulse, waits
// for completion under a watchdog and returns the result with its rd tag.
module mul_issue_ctrl
    import rv32m_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          FAST_ZERO      = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    input  logic [4:0]      req_rd_i,
    input  logic            flush_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_data_o,
    output logic [4:0]      rsp_rd_o,
    output logic            rsp_err_o,
    output logic            busy_o,
    output logic            mult_en_o,
    output logic [XLEN-1:0] op_A_o,
    output logic [XLEN-1:0] op_B_o,
    output logic            signed_A_o,
    output logic            signed_B_o,
    output logic            upper_o,
    input  logic [XLEN-1:0] mult_result_i,
    input  logic            mult_done_i
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state_q;
    state_t          state_d;
    mul_flags_t      dec;
    logic [XLEN-1:0] op_a_q;
    logic [XLEN-1:0] op_b_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_q;
    logic            sa_q;
    logic            sb_q;
    logic            up_q;
    logic            err_q;
    logic [WD_W-1:0] wdog_q;
    logic            accept;
    logic            zero_op;
    logic            wd_expired;

    mul_decode u_decode (
        .funct3 (req_funct3_i),
        .flags  (dec)
    );

    assign accept     = req_valid_i && req_ready_o;
    assign zero_op    = (req_rs1_i == '0) || (req_rs2_i == '0);
    // The last counted cycle is the one in which the counter reads 1.
    assign wd_expired = (wdog_q == WD_W'(1));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!dec.legal || (FAST_ZERO && zero_op)) begin
                        state_d = RESP;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: begin
                state_d = flush_i ? DRAIN : BUSY;
            end
            BUSY: begin
                // A flush coinciding with done means the multiplier has
                // already finished, so there is nothing left to drain.
                if (flush_i) begin
                    state_d = mult_done_i ? IDLE : DRAIN;
                end else if (mult_done_i || wd_expired) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (flush_i || rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (mult_done_i || wd_expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, result capture and watchdog
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            rd_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            up_q     <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            wdog_q   <= '0;
        end else begin
            if (accept) begin
                op_a_q   <= req_rs1_i;
                op_b_q   <= req_rs2_i;
                rd_q     <= req_rd_i;
                sa_q     <= dec.signed_a;
                sb_q     <= dec.signed_b;
                up_q     <= dec.upper;
                err_q    <= !dec.legal;
                result_q <= '0;
            end
            if (state_q == START) begin
                wdog_q <= WD_W'(TIMEOUT_CYCLES);
            end else if ((state_q == BUSY || state_q == DRAIN) && wdog_q != '0) begin
                wdog_q <= wdog_q - WD_W'(1);
            end
            if (state_q == BUSY && !flush_i) begin
                if (mult_done_i) begin
                    result_q <= mult_result_i;
                end else if (wd_expired) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Handshake and control outputs derived from the current state
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        mult_en_o   = 1'b0;
        busy_o      = (state_q != IDLE);
        unique case (state_q)
            IDLE:    req_ready_o = !flush_i;
            START:   mult_en_o   = 1'b1;
            RESP:    rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign rsp_data_o = result_q;
    assign rsp_rd_o   = rd_q;
    assign rsp_err_o  = err_q;
    assign op_A_o     = op_a_q;
    assign op_B_o     = op_b_q;
    assign signed_A_o = sa_q;
    assign signed_B_o = sb_q;
    assign upper_o    = up_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl with a 7-cycle behavioural multiplier.
module tb_mul_issue_ctrl;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned MLAT    = 7;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_funct3_i = '0;
    logic [31:0] req_rs1_i = '0;
    logic [31:0] req_rs2_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        flush_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        mult_en_o;
    logic [31:0] op_A_o;
    logic [31:0] op_B_o;
    logic        signed_A_o;
    logic        signed_B_o;
    logic        upper_o;
    logic [31:0] mult_result_i = '0;
    logic        mult_done_i = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned mcnt     = 0;
    bit          mute     = 1'b0;

    mul_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .FAST_ZERO(1'b1)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_funct3_i  (req_funct3_i),
        .req_rs1_i     (req_rs1_i),
        .req_rs2_i     (req_rs2_i),
        .req_rd_i      (req_rd_i),
        .flush_i       (flush_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_rd_o      (rsp_rd_o),
        .rsp_err_o     (rsp_err_o),
        .busy_o        (busy_o),
        .mult_en_o     (mult_en_o),
        .op_A_o        (op_A_o),
        .op_B_o        (op_B_o),
        .signed_A_o    (signed_A_o),
        .signed_B_o    (signed_B_o),
        .upper_o       (upper_o),
        .mult_result_i (mult_result_i),
        .mult_done_i   (mult_done_i)
    );

    always #5 clk = ~clk;

    // Plain 64-bit product with per-operand sign extension.
    function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b,
                                         input logic sa, input logic sb, input logic up);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return up ? p[63:32] : p[31:0];
    endfunction

    // Expected {err, data} straight from the RV32M instruction semantics.
    function automatic logic [32:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        if (f3[2]) return {1'b1, 32'h0};
        if (a == 32'h0 || b == 32'h0) return {1'b0, 32'h0};
        return {1'b0, prod(a, b, f3 != 3'd3, f3 <= 3'd1, f3 != 3'd0)};
    endfunction

    // Behavioural multiplier: done pulses MLAT cycles after the enable cycle.
    always @(negedge clk) begin
        mult_done_i = 1'b0;
        if (rst_i) begin
            mcnt = 0;
        end else begin
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0 && !mute) begin
                    mult_done_i   = 1'b1;
                    mult_result_i = prod(op_A_o, op_B_o, signed_A_o, signed_B_o, upper_o);
                end
            end
            if (mult_en_o) mcnt = MLAT;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    // Issue one request from IDLE (called at a negedge) and collect the response.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int unsigned hold,
                          output logic [31:0] data, output logic err, output logic [4:0] rdo,
                          output int unsigned en_cnt, output int unsigned rsp_idx,
                          output logic [2:0] flags, output bit ready_ok, output bit stable_ok,
                          output bit timed_out);
        data = '0; err = 1'b0; rdo = '0; en_cnt = 0; rsp_idx = 0; flags = '0;
        ready_ok = 1'b1; stable_ok = 1'b1; timed_out = 1'b1;
        req_valid_i  = 1'b1;
        req_funct3_i = f3;
        req_rs1_i    = a;
        req_rs2_i    = b;
        req_rd_i     = rd;
        @(negedge clk);
        req_valid_i  = 1'b0;
        req_rs1_i    = $urandom;
        req_rs2_i    = $urandom;
        req_rd_i     = 5'($urandom);
        for (int unsigned c = 1; c <= 200; c++) begin
            if (req_ready_o) ready_ok = 1'b0;
            if (mult_en_o) begin
                en_cnt++;
                flags = {signed_A_o, signed_B_o, upper_o};
            end
            if (rsp_valid_o) begin
                rsp_idx   = c;
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (!timed_out) begin
            data = rsp_data_o;
            err  = rsp_err_o;
            rdo  = rsp_rd_o;
            for (int unsigned h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!rsp_valid_o || rsp_data_o !== data || rsp_rd_o !== rdo ||
                    rsp_err_o !== err || req_ready_o) stable_ok = 1'b0;
            end
            rsp_ready_i = 1'b1;
            @(negedge clk);
            rsp_ready_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_ready_o, rsp_valid_o, busy_o, mult_en_o, rsp_err_o} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 10000", {req_ready_o, rsp_valid_o, busy_o, mult_en_o, rsp_err_o});
        end
        n_checks++;
        if ({op_A_o, op_B_o, rsp_data_o, rsp_rd_o, signed_A_o, signed_B_o, upper_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: opA %h opB %h data %h rd %h required all zero", op_A_o, op_B_o, rsp_data_o, rsp_rd_o);
        end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul_basic();
        logic [31:0] d; logic e; logic [4:0] r; logic [2:0] fl;
        int unsigned en; int unsigned idx; bit rok; bit sok; bit to;
        run_op(3'b000, 32'd6, 32'd7, 5'd5, 0, d, e, r, en, idx, fl, rok, sok, to);
        n_checks++;
        if (to || {e, r, d} !== {1'b0, 5'd5, 32'h2A}) begin
            n_fail++;
            $display("FAIL mul_basic: timeout %0d err %b rd %0d data %h required 0 5 0000002a", to, e, r, d);
        end
        n_checks++;
        if (en !== 1 || idx !== MLAT + 2) begin
            n_fail++;
            $display("FAIL mul_timing: en pulses %0d rsp cycle %0d required 1 and %0d", en, idx, MLAT + 2);
        end
        n_checks++;
        if (fl !== 3'b110 || rok !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_flags_ready: flags %b ready_low %b required 110 1", fl, rok);
        end
    endtask

    task automatic test_mulh_variants();
        logic [31:0] d; logic e; logic [4:0] r; logic [2:0] fl;
        int unsigned en; int unsigned idx; bit rok; bit sok; bit to;
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 0, d, e, r, en, idx, fl, rok, sok, to);
        n_checks++;
        if (to || fl !== 3'b001 || d !== 32'hFFFF_FFFE || e !== 1'b0 || r !== 5'd9) begin
            n_fail++;
            $display("FAIL mulhu: flags %b data %h err %b rd %0d required 001 fffffffe 0 9", fl, d, e, r);
        end
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd10, 0, d, e, r, en, idx, fl, rok, sok, to);
        n_checks++;
        if (to || fl !== 3'b101 || d !== 32'hFFFF_FFFF || e !== 1'b0) begin
            n_fail++;
            $display("FAIL mulhsu: flags %b data %h err %b required 101 ffffffff 0", fl, d, e);
        end
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd11, 0, d, e, r, en, idx, fl, rok, sok, to);
        n_checks++;
        if (to || fl !== 3'b111 || d !== 32'h4000_0000) begin
            n_fail++;
            $display("FAIL mulh: flags %b data %h required 111 40000000", fl, d);
        end
    endtask

    task automatic test_fast_paths();
        logic [31:0] d; logic e; logic [4:0] r; logic [2:0] fl;
        int unsigned en; int unsigned idx; bit rok; bit sok; bit to;
        run_op(3'b100, 32'd3, 32'd4, 5'd7, 0, d, e, r, en, idx, fl, rok, sok, to);
        n_checks++;
        if (to || idx !== 1 || en !== 0 || e !== 1'b1 || d !== 32'h0 || r !== 5'd7) begin
            n_fail++;
            $display("FAIL illegal_f3: cycle %0d en %0d err %b data %h rd %0d required 1 0 1 0 7", idx, en, e, d, r);
        end
        run_op(3'b000, 32'h0, 32'h1234, 5'd8, 0, d, e, r, en, idx, fl, rok, sok, to);
        n_checks++;
        if (to || idx !== 1 || en !== 0 || e !== 1'b0 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_fast: cycle %0d en %0d err %b data %h required 1 0 0 0", idx, en, e, d);
        end
        run_op(3'b011, 32'h5555, 32'h0, 5'd8, 0, d, e, r, en, idx, fl, rok, sok, to);
        n_checks++;
        if (to || idx !== 1 || en !== 0 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_fast_rs2: cycle %0d en %0d data %h required 1 0 0", idx, en, d);
        end
    endtask

    task automatic test_flush();
        int unsigned idle_idx;
        bit saw_rsp;
        logic [31:0] d; logic e; logic [4:0] r; logic [2:0] fl;
        int unsigned en; int unsigned idx; bit rok; bit sok; bit to;
        req_valid_i = 1'b1; req_funct3_i = 3'b000; req_rs1_i = 32'd100; req_rs2_i = 32'd3; req_rd_i = 5'd2;
        @(negedge clk);
        req_valid_i = 1'b0;
        n_checks++;
        if (mult_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_start: mult_en %b required 1", mult_en_o);
        end
        repeat (3) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1 || op_A_o !== 32'd100 || op_B_o !== 32'd3) begin
            n_fail++;
            $display("FAIL flush_drain_hold: busy %b opA %h opB %h required 1 64 3", busy_o, op_A_o, op_B_o);
        end
        idle_idx = 0;
        saw_rsp  = 1'b0;
        for (int unsigned c = 5; c <= 20; c++) begin
            if (rsp_valid_o) saw_rsp = 1'b1;
            if (!busy_o && idle_idx == 0) idle_idx = c;
            @(negedge clk);
        end
        n_checks++;
        if (saw_rsp || idle_idx !== MLAT + 2) begin
            n_fail++;
            $display("FAIL flush_drain: rsp seen %b idle at %0d required 0 and %0d", saw_rsp, idle_idx, MLAT + 2);
        end
        run_op(3'b000, 32'd9, 32'd9, 5'd4, 0, d, e, r, en, idx, fl, rok, sok, to);
        n_checks++;
        if (to || d !== 32'd81 || r !== 5'd4 || idx !== MLAT + 2) begin
            n_fail++;
            $display("FAIL flush_next_req: data %h rd %0d cycle %0d required 51 4 %0d", d, r, idx, MLAT + 2);
        end
        // Flush while a response is pending drops it.
        req_valid_i = 1'b1; req_funct3_i = 3'b000; req_rs1_i = 32'h0; req_rs2_i = 32'd5;
        @(negedge clk);
        req_valid_i = 1'b0;
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        n_checks++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_resp: rsp_valid %b busy %b required 0 0", rsp_valid_o, busy_o);
        end
        // Flush alongside a request in IDLE blocks acceptance.
        req_valid_i = 1'b1; flush_i = 1'b1; req_rs1_i = 32'd2; req_rs2_i = 32'd2;
        @(negedge clk);
        req_valid_i = 1'b0; flush_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || mult_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_req: busy %b mult_en %b required 0 0", busy_o, mult_en_o);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic e; logic [4:0] r; logic [2:0] fl;
        int unsigned en; int unsigned idx; bit rok; bit sok; bit to;
        mute = 1'b1;
        run_op(3'b000, 32'd3, 32'd5, 5'd12, 0, d, e, r, en, idx, fl, rok, sok, to);
        mute = 1'b0;
        n_checks++;
        if (to || e !== 1'b1 || d !== 32'h0 || r !== 5'd12 || en !== 1) begin
            n_fail++;
            $display("FAIL watchdog_rsp: err %b data %h rd %0d en %0d required 1 0 12 1", e, d, r, en);
        end
        n_checks++;
        if (idx !== TIMEOUT + 2) begin
            n_fail++;
            $display("FAIL watchdog_time: rsp cycle %0d required %0d", idx, TIMEOUT + 2);
        end
    endtask

    task automatic test_stall();
        logic [31:0] d; logic e; logic [4:0] r; logic [2:0] fl;
        int unsigned en; int unsigned idx; bit rok; bit sok; bit to;
        run_op(3'b000, 32'hDEAD, 32'h10, 5'd21, 5, d, e, r, en, idx, fl, rok, sok, to);
        n_checks++;
        if (to || sok !== 1'b1 || d !== 32'h000D_EAD0 || r !== 5'd21) begin
            n_fail++;
            $display("FAIL stall_stable: stable %b data %h rd %0d required 1 000dead0 21", sok, d, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1; logic e1; logic [4:0] r1;
        logic [31:0] d2; logic e2; logic [4:0] r2; logic [2:0] fl;
        int unsigned en; int unsigned idx; bit rok; bit sok; bit to1; bit to2;
        logic rdy;
        run_op(3'b000, 32'd11, 32'd13, 5'd1, 0, d1, e1, r1, en, idx, fl, rok, sok, to1);
        rdy = req_ready_o;
        run_op(3'b011, 32'h1_0000, 32'h3_0000, 5'd2, 0, d2, e2, r2, en, idx, fl, rok, sok, to2);
        n_checks++;
        if (rdy !== 1'b1 || idx !== MLAT + 2) begin
            n_fail++;
            $display("FAIL b2b_ready: ready after handshake %b second rsp cycle %0d required 1 %0d", rdy, idx, MLAT + 2);
        end
        n_checks++;
        if (to1 || to2 || {r1, d1, r2, d2} !== {5'd1, 32'd143, 5'd2, 32'h3}) begin
            n_fail++;
            $display("FAIL b2b_order: rd %0d data %h then rd %0d data %h required 1 8f then 2 3", r1, d1, r2, d2);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_rsp;
        logic [31:0] d; logic e; logic [4:0] r; logic [2:0] fl;
        int unsigned en; int unsigned idx; bit rok; bit sok; bit to;
        req_valid_i = 1'b1; req_funct3_i = 3'b000; req_rs1_i = 32'd3; req_rs2_i = 32'd4; req_rd_i = 5'd6;
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || op_A_o !== 32'h0 || req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: busy %b rsp_valid %b opA %h ready %b required 0 0 0 1", busy_o, rsp_valid_o, op_A_o, req_ready_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        saw_rsp = 1'b0;
        repeat (12) begin
            if (rsp_valid_o || busy_o) saw_rsp = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (saw_rsp) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: activity seen %b required 0", saw_rsp);
        end
        run_op(3'b000, 32'd12, 32'd12, 5'd6, 0, d, e, r, en, idx, fl, rok, sok, to);
        n_checks++;
        if (to || d !== 32'd144 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_next: data %h err %b required 90 0", d, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] a; logic [31:0] b; logic [2:0] f3; logic [4:0] rd;
        logic [32:0] exp;
        int unsigned sel; int unsigned exp_en; int unsigned exp_idx;
        logic [31:0] d; logic e; logic [4:0] r; logic [2:0] fl;
        int unsigned en; int unsigned idx; bit rok; bit sok; bit to;
        for (int unsigned i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            f3  = (sel < 8) ? 3'(sel & 3) : 3'(4 + (sel & 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) a = 32'h0;
            if (sel == 1) b = 32'h0;
            if (sel == 2) a = 32'h8000_0000;
            if (sel == 3) b = 32'hFFFF_FFFF;
            rd  = 5'($urandom);
            exp = ref_mul(f3, a, b);
            exp_en  = (exp[32] || a == 32'h0 || b == 32'h0) ? 0 : 1;
            exp_idx = (exp_en == 1) ? MLAT + 2 : 1;
            run_op(f3, a, b, rd, $urandom_range(0, 3), d, e, r, en, idx, fl, rok, sok, to);
            n_checks++;
            if (to || {e, d} !== exp || r !== rd || en !== exp_en || idx !== exp_idx || !sok || !rok) begin
                n_fail++;
                $display("FAIL random[%0d]: f3 %b a %h b %h got err %b data %h rd %0d en %0d cyc %0d required err %b data %h rd %0d en %0d cyc %0d",
                         i, f3, a, b, e, d, r, en, idx, exp[32], exp[31:0], rd, exp_en, exp_idx);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mul_basic();
        test_mulh_variants();
        test_fast_paths();
        test_flush();
        test_timeout();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
